// File: rtl/mul_iter_if.sv
// Handshake and result bundle for the iterative multiplier.
// The master issues operands; the slave returns the product and flags.
interface mul_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic             is_long;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             flag_64b;
    logic [1:0]       flags_nz;

    modport master (
        output start, is_signed, is_long, a, b,
        input  busy, done, result_lo, result_hi,
        input  flag_64b, flags_nz
    );

    modport slave (
        input  start, is_signed, is_long, a, b,
        output busy, done, result_lo, result_hi,
        output flag_64b, flags_nz
    );
endinterface

// File: rtl/mul_iter.sv
// Radix-2 shift-add multiplier: magnitudes in, one add/shift per cycle,
// optional two's-complement fix-up, then results and {N,Z} are latched.
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    mul_iter_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        NEG,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic               signed_q, signed_d;
    logic               long_q, long_d;
    logic               ph_q, ph_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic               f64_q, f64_d;
    logic [1:0]         nz_q, nz_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum;
    logic               n_flag, z_flag;

    always_comb begin
        a_mag = bus.a;
        b_mag = bus.b;
        if (bus.is_signed && bus.a[WIDTH-1]) a_mag = -bus.a;
        if (bus.is_signed && bus.b[WIDTH-1]) b_mag = -bus.b;
    end

    assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (mplr_q[0] ? {1'b0, mcand_q} : '0);

    assign n_flag = long_q ? acc_q[2*WIDTH-1] : acc_q[WIDTH-1];
    assign z_flag = long_q ? (acc_q == '0)
                           : (acc_q[WIDTH-1:0] == '0);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        signed_d = signed_q;
        long_d   = long_q;
        ph_d     = ph_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        f64_d    = f64_q;
        nz_d     = nz_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    signed_d = bus.is_signed;
                    long_d   = bus.is_long;
                    mcand_d  = a_mag;
                    mplr_d   = b_mag;
                    sign_d   = bus.is_signed
                             & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
                    ph_d     = 1'b0;
                end
            end
            RUN: begin
                acc_d  = {sum, acc_q[WIDTH-1:1]};
                mplr_d = mplr_q >> 1;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = NEG;
            end
            NEG: begin
                // First NEG cycle fixes the sign, second latches results.
                if (!ph_q) begin
                    if (sign_q && signed_q) acc_d = -acc_q;
                    ph_d = 1'b1;
                end else begin
                    ph_d     = 1'b0;
                    state_d  = DONE;
                    res_lo_d = acc_q[WIDTH-1:0];
                    res_hi_d = acc_q[2*WIDTH-1:WIDTH];
                    f64_d    = long_q;
                    nz_d     = {n_flag, z_flag};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            signed_q <= 1'b0;
            long_q   <= 1'b0;
            ph_q     <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            f64_q    <= 1'b0;
            nz_q     <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            signed_q <= signed_d;
            long_q   <= long_d;
            ph_q     <= ph_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            f64_q    <= f64_d;
            nz_q     <= nz_d;
        end
    end

    assign bus.busy      = (state_q == RUN) || (state_q == NEG);
    assign bus.done      = (state_q == DONE);
    assign bus.result_lo = res_lo_q;
    assign bus.result_hi = res_hi_q;
    assign bus.flag_64b  = f64_q;
    assign bus.flags_nz  = nz_q;
endmodule

// File: tb/tb_mul_iter.sv
// Scoreboard bench for mul_iter: directed operands with hand-computed
// products; a monitor pops expectations whenever done pulses.
module tb_mul_iter;
    localparam int W = 32;
    localparam int LAT = W + 2;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         f64;
        logic [1:0]   nz;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    mul_iter_if #(.WIDTH(W)) bus ();

    mul_iter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL stray_done: got done at cyc %0d want none",
                         cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("lo", 64'(bus.result_lo), 64'(e.lo));
                chk("hi", 64'(bus.result_hi), 64'(e.hi));
                chk("f64", 64'(bus.flag_64b), 64'(e.f64));
                chk("nz", 64'(bus.flags_nz), 64'(e.nz));
                chk("latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Caller is at a negedge; start is sampled on the next posedge.
    task automatic issue(input logic sg, input logic lg,
                         input logic [W-1:0] av,
                         input logic [W-1:0] bv,
                         input logic push,
                         input logic [W-1:0] elo,
                         input logic [W-1:0] ehi,
                         input logic [1:0] enz);
        exp_t e;
        bus.start     = 1'b1;
        bus.is_signed = sg;
        bus.is_long   = lg;
        bus.a         = av;
        bus.b         = bv;
        if (push) begin
            e.lo  = elo;
            e.hi  = ehi;
            e.f64 = lg;
            e.nz  = enz;
            e.due = cyc + 1 + LAT;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic sg, input logic lg,
                       input logic [W-1:0] av,
                       input logic [W-1:0] bv,
                       input logic [W-1:0] elo,
                       input logic [W-1:0] ehi,
                       input logic [1:0] enz);
        issue(sg, lg, av, bv, 1'b1, elo, ehi, enz);
        wait_empty();
    endtask

    initial begin
        int t0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.is_long   = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy_done", 64'({bus.busy, bus.done}), 64'd0);
        chk("rst_res", {bus.result_hi, bus.result_lo}, 64'd0);
        chk("rst_flags", 64'({bus.flag_64b, bus.flags_nz}), 64'd0);
        reset = 1'b0;

        // Accepted on the very first edge after release.
        run(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'h0000_0001, 32'hFFFF_FFFE, 2'b10);
        run(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001,
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10);
        run(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000,
            32'h0000_0000, 32'h4000_0000, 2'b00);
        run(1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000,
            32'h0000_0000, 32'h0000_0001, 2'b01);
        run(1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFB,
            32'h0000_0000, 32'h0000_0000, 2'b01);
        run(1'b1, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007,
            32'hFFFF_FFEB, 32'hFFFF_FFFF, 2'b10);
        run(1'b0, 1'b0, 32'd12345, 32'd678,
            32'h007F_B6F6, 32'h0000_0000, 2'b00);
        run(1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0003,
            32'hFFFF_FFFA, 32'hFFFF_FFFF, 2'b10);

        // Re-pulsed start and operand churn while busy.
        issue(1'b0, 1'b1, 32'h1234_5678, 32'h0000_0100, 1'b1,
              32'h3456_7800, 32'h0000_0012, 2'b00);
        t0 = cyc;
        repeat (4) @(negedge clk);
        chk("busy_run", 64'(bus.busy), 64'd1);
        bus.start     = 1'b1;
        bus.is_signed = 1'b1;
        bus.is_long   = 1'b0;
        bus.a         = 32'hDEAD_BEEF;
        bus.b         = 32'h8765_4321;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < t0 + 33) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_empty();
        repeat (40) @(negedge clk);
        chk("idle_after", 64'({bus.busy, bus.done}), 64'd0);

        // Reset in the middle of RUN aborts with no done pulse.
        issue(1'b0, 1'b1, 32'h0000_0003, 32'h0000_0005, 1'b0,
              32'h0, 32'h0, 2'b00);
        repeat (9) @(negedge clk);
        chk("busy_pre_rst", 64'(bus.busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy_done", 64'({bus.busy, bus.done}), 64'd0);
        chk("abort_res", {bus.result_hi, bus.result_lo}, 64'd0);
        chk("abort_flags", 64'({bus.flag_64b, bus.flags_nz}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'h0000_0001, 32'h0000_0000, 2'b00);
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mul_iter.md
MUL_ITER -- requirements
Module: mul_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width; the product width is 2*WIDTH.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply, sampled only in IDLE.
REQ-005 SHALL have port is_signed, input, 1 bit: 1 means two's-complement operands (SMULL), 0 means unsigned (UMULL/MUL).
REQ-006 SHALL have port is_long, input, 1 bit: 1 means a 64-bit result is written (drives the controller's Flag_64b path), 0 means a 32-bit MUL.
REQ-007 SHALL have port a, input, WIDTH bits: multiplicand (Rn).
REQ-008 SHALL have port b, input, WIDTH bits: multiplier (Rm).
REQ-009 SHALL have port busy, output, 1 bit: high while a multiply is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse indicating that the results are valid.
REQ-011 SHALL have port result_lo, output, WIDTH bits: low word of the product.
REQ-012 SHALL have port result_hi, output, WIDTH bits: high word of the product.
REQ-013 SHALL have port flag_64b, output, 1 bit: the latched is_long of the completed operation.
REQ-014 SHALL have port flags_nz, output, 2 bits: {N,Z} of the completed result.

Function
REQ-015 SHALL implement the states IDLE, RUN, NEG and DONE.
REQ-016 IDLE SHALL go to RUN on start=1; in the same edge it SHALL latch is_signed, is_long, |a|, |b| (magnitudes only when is_signed=1), sign=a[MSB]^b[MSB] (sign forced to 0 when unsigned), clear the accumulator, and load the iteration counter with WIDTH.
REQ-017 RUN SHALL perform one radix-2 shift-add step per cycle: if the current multiplier LSB is 1, add the multiplicand to the upper accumulator half (carry kept); then shift the accumulator right by 1.
REQ-018 RUN SHALL last exactly WIDTH cycles and then go to NEG.
REQ-019 NEG SHALL replace the 2*WIDTH product with its two's complement when sign=1, else leave it unchanged; it SHALL then go to DONE.
REQ-020 DONE SHALL last exactly one cycle and then go to IDLE.
REQ-021 Latency: with start sampled at edge T, done SHALL be high during the cycle following edge T+WIDTH+2 (34 cycles for WIDTH=32).
REQ-022 busy SHALL be 1 in RUN and NEG, and 0 in IDLE and DONE.
REQ-023 done SHALL be 1 only in DONE.
REQ-024 result_lo, result_hi, flag_64b and flags_nz SHALL be updated on entry to DONE and held stable until the next DONE.
REQ-025 N SHALL equal result_hi[MSB] when is_long=1, else result_lo[MSB].
REQ-026 Z SHALL be 1 iff the full 2*WIDTH product is zero when is_long=1, else iff result_lo is zero.
REQ-027 start SHALL be ignored in RUN, NEG and DONE, with no queuing.
REQ-028 Changes on a, b, is_signed or is_long after acceptance SHALL NOT affect the operation in flight.
REQ-029 The signed most-negative operand (0x80000000) SHALL be handled as magnitude 2^31 without overflow.
REQ-030 A zero operand with sign=1 SHALL yield a product of 0 and Z=1.

Reset
REQ-031 reset SHALL immediately force IDLE and clear busy, done, result_lo, result_hi, flag_64b, flags_nz, the accumulator, the counter and all latched operands.
REQ-032 reset asserted mid-RUN or mid-NEG SHALL abort the operation; done SHALL NOT pulse afterwards.
REQ-033 After reset is released, the first start SHALL be accepted on the first clock edge.

Verification
REQ-034 Unsigned long, a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, N=1, Z=0, done 34 cycles after start.
REQ-035 Signed long, a=0xFFFFFFFF (-1), b=0x00000001 -> hi=lo=0xFFFFFFFF, N=1, flag_64b=1.
REQ-036 Signed long, a=b=0x80000000 -> hi=0x40000000, lo=0x00000000, N=0, Z=0.
REQ-037 Short MUL, a=0x00010000, b=0x00010000 -> lo=0x00000000, hi=0x00000001, Z=1 (low word only), flag_64b=0.
REQ-038 start re-pulsed at cycles 5 and 33 of a run -> both ignored; exactly one done pulse; operand changes mid-run leave the result unaffected.
REQ-039 reset asserted at RUN cycle 10 -> busy=0 and all outputs 0 immediately; no done pulse; a new start after release completes in 34 cycles with the correct product.
